// File: rtl/eyeriss_arith_pkg.sv
// Shared arithmetic definitions for the PE datapath: default width, divider
// state encoding and signed saturation constants.
package eyeriss_arith_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam logic [DATA_W_DEF-1:0] SAT_POS = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic [DATA_W_DEF-1:0] SAT_NEG = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_restore_step #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] prem,
    input  logic              bit_in,
    input  logic [DATA_W-1:0] dvs_mag,
    output logic [DATA_W-1:0] prem_next,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] dvs_ext;

    assign shifted   = {prem, bit_in};
    assign dvs_ext   = {1'b0, dvs_mag};
    assign q_bit     = (shifted >= dvs_ext);
    assign prem_next = q_bit ? DATA_W'(shifted - dvs_ext) : shifted[DATA_W-1:0];

endmodule

// File: rtl/seq_div_time.sv
// Multi-cycle signed 2W/W restoring divider (inverse of booth_time).
// Define SEQ_DIV_EARLY_EXIT_EN to skip the iteration loop for divide-by-zero and pre-overflow.
module seq_div_time
    import eyeriss_arith_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  vld_in,
    input  logic [2*DATA_W-1:0]   dividend,
    input  logic [DATA_W-1:0]     divisor,
    output logic [DATA_W-1:0]     quotient,
    output logic [DATA_W-1:0]     remainder,
    output logic                  done,
    output logic                  busy,
    output logic                  ovf,
    output logic                  dz
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] sat_val(input logic neg);
        return neg ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag, input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    div_state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   prem;
    logic [DATA_W-1:0]   lo_q;      // low dividend bits shift out of the top, quotient bits in at the bottom
    logic [DATA_W-1:0]   dvs_mag;
    logic                sign_q, sign_r, pre_ovf, dz_flag;

    logic                accept;
    logic [2*DATA_W-1:0] dvd_abs;
    logic [DATA_W-1:0]   dvs_abs;
    logic                dz_now, pre_ovf_now;
    logic [DATA_W-1:0]   prem_nxt;
    logic                q_bit;
    logic                post_ovf;

    assign accept      = (state == ST_IDLE) && vld_in;
    assign dvd_abs     = dividend[2*DATA_W-1] ? (~dividend + 1'b1) : dividend;
    assign dvs_abs     = divisor[DATA_W-1] ? (~divisor + 1'b1) : divisor;
    assign dz_now      = (divisor == '0);
    assign pre_ovf_now = (dvd_abs[2*DATA_W-1:DATA_W] >= dvs_abs);

    // Negative results may reach magnitude 2^(W-1); positive ones must stay below it.
    assign post_ovf = lo_q[DATA_W-1] & (~sign_q | (|lo_q[DATA_W-2:0]));

    assign done = (state == ST_DONE);
    assign busy = (state != ST_IDLE);

    div_restore_step #(.DATA_W(DATA_W)) u_step (
        .prem      (prem),
        .bit_in    (lo_q[DATA_W-1]),
        .dvs_mag   (dvs_mag),
        .prem_next (prem_nxt),
        .q_bit     (q_bit)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (vld_in) begin
`ifdef SEQ_DIV_EARLY_EXIT_EN
                    state_nxt = (dz_now || pre_ovf_now) ? ST_FIX : ST_RUN;
`else
                    state_nxt = ST_RUN;
`endif
                end
            end
            ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            prem      <= '0;
            lo_q      <= '0;
            dvs_mag   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            pre_ovf   <= 1'b0;
            dz_flag   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= '0;
                prem    <= dvd_abs[2*DATA_W-1:DATA_W];
                lo_q    <= dvd_abs[DATA_W-1:0];
                dvs_mag <= dvs_abs;
                sign_q  <= dividend[2*DATA_W-1] ^ divisor[DATA_W-1];
                sign_r  <= dividend[2*DATA_W-1];
                pre_ovf <= pre_ovf_now;
                dz_flag <= dz_now;
            end else if (state == ST_RUN) begin
                cnt  <= cnt + 1'b1;
                prem <= prem_nxt;
                lo_q <= {lo_q[DATA_W-2:0], q_bit};
            end

            if (state == ST_FIX) begin
                if (dz_flag) begin
                    quotient  <= sat_val(sign_r);
                    remainder <= '0;
                    ovf       <= 1'b0;
                    dz        <= 1'b1;
                end else if (pre_ovf || post_ovf) begin
                    quotient  <= sat_val(sign_q);
                    remainder <= '0;
                    ovf       <= 1'b1;
                    dz        <= 1'b0;
                end else begin
                    quotient  <= apply_sign(lo_q, sign_q);
                    remainder <= apply_sign(prem, sign_r);
                    ovf       <= 1'b0;
                    dz        <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_div_time.sv
// Directed self-checking bench for seq_div_time (DATA_W = 16).
module tb_seq_div_time;

`ifdef SEQ_DIV_EARLY_EXIT_EN
    localparam int LAT_EE = 1;
`else
    localparam int LAT_EE = 17;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        vld_in;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient, remainder;
    logic        done, busy, ovf, dz;

    int n_asrt = 0;
    int n_fail = 0;
    int lat;

    seq_div_time #(.DATA_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .vld_in    (vld_in),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .busy      (busy),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            #1;
            if (!done) chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end while (!done && cycles < 40);
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                          input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                          input logic eovf, input logic edz);
        int cyc;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        vld_in   = 1'b1;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        wait_done(tag, cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
        chk({tag, "_r"}, {16'd0, remainder}, {16'd0, er});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
        chk({tag, "_dz"}, {31'd0, dz}, {31'd0, edz});
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rstn     = 1'b0;
        vld_in   = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_q", {16'd0, quotient}, 32'd0);
        chk("rst_r", {16'd0, remainder}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        run_op("booth", 32'h06F9_0000, 16'd13056, 17, 16'h2300, 16'h0000, 1'b0, 1'b0);
        run_op("booth_neg", 32'hF907_0000, 16'd13056, 17, 16'hDD00, 16'h0000, 1'b0, 1'b0);
        run_op("m7_div2", 32'hFFFF_FFF9, 16'd2, 17, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        run_op("d100_3", 32'd100, 16'd3, 17, 16'h0021, 16'h0001, 1'b0, 1'b0);
        run_op("dz_pos", 32'd100, 16'd0, LAT_EE, 16'h7FFF, 16'h0000, 1'b0, 1'b1);
        run_op("dz_neg", 32'hFFFF_FFFB, 16'd0, LAT_EE, 16'h8000, 16'h0000, 1'b0, 1'b1);
        run_op("pre_ovf", 32'h0001_0000, 16'd1, LAT_EE, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
        run_op("m32768_1", 32'hFFFF_8000, 16'd1, 17, 16'h8000, 16'h0000, 1'b0, 1'b0);
        run_op("p32768_m1", 32'h0000_8000, 16'hFFFF, 17, 16'h8000, 16'h0000, 1'b0, 1'b0);
        run_op("m32768_m1", 32'hFFFF_8000, 16'hFFFF, 17, 16'h7FFF, 16'h0000, 1'b1, 1'b0);

        // Reset during RUN: outputs drop at once, then a fresh operation still works
        @(negedge clk);
        dividend = 32'h06F9_0000;
        divisor  = 16'd13056;
        vld_in   = 1'b1;
        @(posedge clk);
        #1;
        vld_in = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_q", {16'd0, quotient}, 32'd0);
        chk("mid_rst_r", {16'd0, remainder}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        chk("mid_rst_dz", {31'd0, dz}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        run_op("post_rst", 32'h06F9_0000, 16'd13056, 17, 16'h2300, 16'h0000, 1'b0, 1'b0);

        // vld_in held high: back-to-back accepts 19 edges apart, operand changes mid-RUN ignored
        @(negedge clk);
        dividend = 32'hFFFF_FFF9;
        divisor  = 16'd2;
        vld_in   = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_busy_e0", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("hs_busy_run", {31'd0, busy}, 32'd1);
        end
        dividend = 32'd100;
        divisor  = 16'd3;
        wait_done("hs1", lat);
        chk("hs1_lat", 32'(lat + 4), 32'd17);
        chk("hs1_q", {16'd0, quotient}, 32'h0000_FFFD);
        chk("hs1_r", {16'd0, remainder}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        chk("hs_e18_idle", {31'd0, busy}, 32'd0);
        chk("hs_e18_pulse", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("hs_e19_accept", {31'd0, busy}, 32'd1);
        vld_in = 1'b0;
        wait_done("hs2", lat);
        chk("hs2_lat", 32'(lat), 32'd17);
        chk("hs2_q", {16'd0, quotient}, 32'h0000_0021);
        chk("hs2_r", {16'd0, remainder}, 32'h0000_0001);
        @(posedge clk);
        #1;
        chk("hs2_pulse", {31'd0, done}, 32'd0);
        chk("hs2_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
